// File: rtl/piso_serial_tx.sv
// Parallel-in serial-out transmitter: accepts a word on a valid/ready handshake and
// shifts it out one bit per shift_en cycle, then pulses done for one cycle.
module piso_serial_tx #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned MSB_FIRST = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [WIDTH-1:0]           din,
    input  logic                       load_valid,
    output logic                       load_ready,
    input  logic                       shift_en,
    output logic                       sout,
    output logic                       frame,
    output logic                       done,
    output logic [$clog2(WIDTH)-1:0]   bit_cnt
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] sreg_adv;
    logic             first_bit;
    logic             next_bit;

    // sout is registered, so the bit that will be on sout after an advance is
    // taken from the already-shifted register value.
    always_comb begin
        if (MSB_FIRST != 0) begin
            sreg_adv  = {sreg[WIDTH-2:0], 1'b0};
            first_bit = din[WIDTH-1];
            next_bit  = sreg_adv[WIDTH-1];
        end else begin
            sreg_adv  = {1'b0, sreg[WIDTH-1:1]};
            first_bit = din[0];
            next_bit  = sreg_adv[0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            sreg       <= '0;
            bit_cnt    <= '0;
            sout       <= 1'b0;
            frame      <= 1'b0;
            done       <= 1'b0;
            load_ready <= 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    done       <= 1'b0;
                    frame      <= 1'b0;
                    sout       <= 1'b0;
                    bit_cnt    <= '0;
                    load_ready <= 1'b1;
                    if (load_valid) begin
                        sreg       <= din;
                        sout       <= first_bit;
                        frame      <= 1'b1;
                        load_ready <= 1'b0;
                        state      <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (shift_en) begin
                        if (bit_cnt == LAST) begin
                            sreg    <= '0;
                            sout    <= 1'b0;
                            frame   <= 1'b0;
                            done    <= 1'b1;
                            bit_cnt <= '0;
                            state   <= DONE;
                        end else begin
                            sreg    <= sreg_adv;
                            sout    <= next_bit;
                            bit_cnt <= bit_cnt + CW'(1);
                        end
                    end
                end
                DONE: begin
                    done       <= 1'b0;
                    load_ready <= 1'b1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
